// File: rtl/lcm_pkg.sv
// Shared types and constants for the lcm_unit datapath and its division step.
package lcm_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } lcm_state_e;

endpackage

// File: rtl/lcm_unit_seq_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and emit the quotient bit.
module seq_div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem,
  input  logic         din,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  // One extra bit keeps the compare exact even if rem has its MSB set.
  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted  = {rem, din};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/lcm_unit.sv
// Sequential LCM stage: lcm = (a / gcd) * b using an 8-step restoring divider
// followed by an 8-step shift-add multiplier, with a one-cycle done pulse.
module lcm_unit
  import lcm_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   gcd,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] lcm,
  output lcm_state_e     state_dbg
);

  // Handshake: in_valid is a single-cycle strobe honoured only in IDLE; there
  // is no ready, so strobes arriving while busy is high are dropped.

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

  lcm_state_e state, state_next;

  logic [W-1:0]   dvd;
  logic [W-1:0]   b_r;
  logic [W-1:0]   g_r;
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0] lcm_r;

  logic [W-1:0] rem_next;
  logic         q_bit;
  logic         any_zero;
  logic         last_step;

  assign any_zero  = (a == '0) || (b == '0) || (gcd == '0);
  assign last_step = (cnt == LAST_STEP);

  seq_div_step #(.W(W)) u_div_step (
    .rem      (rem),
    .din      (dvd[W-1]),
    .divisor  (g_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign acc_next = quo[cnt] ? acc + ({{W{1'b0}}, b_r} << cnt) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = any_zero ? DONE : DIV;
      DIV:     if (last_step) state_next = MUL;
      MUL:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd   <= '0;
      b_r   <= '0;
      g_r   <= '0;
      rem   <= '0;
      quo   <= '0;
      acc   <= '0;
      cnt   <= '0;
      lcm_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd <= a;
            b_r <= b;
            g_r <= gcd;
            rem <= '0;
            quo <= '0;
            acc <= '0;
            cnt <= '0;
            if (any_zero) lcm_r <= '0;
          end
        end
        DIV: begin
          dvd <= {dvd[W-2:0], 1'b0};
          rem <= rem_next;
          quo <= {quo[W-2:0], q_bit};
          if (last_step) begin
            cnt <= '0;
            acc <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          // Result lands on the same edge that enters DONE.
          if (last_step) lcm_r <= acc_next;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign lcm       = lcm_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_lcm_unit.sv
// Self-checking bench for lcm_unit: directed corner cases plus random operands
// checked against an arithmetic LCM model and a Euclid GCD source.
module tb_lcm_unit;
  import lcm_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a, b, gcd;
  logic        busy, done;
  logic [15:0] lcm;
  lcm_state_e  state_dbg;

  logic [15:0] exp_q[$];
  logic [15:0] exp_hold;
  int          n_checks;
  int          n_fail;

  lcm_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .gcd       (gcd),
    .busy      (busy),
    .done      (done),
    .lcm       (lcm),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gcd_ref(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [15:0] lcm_ref(input int x, input int y, input int g);
    if (x == 0 || y == 0 || g == 0) return 16'd0;
    return 16'((x / g) * y);
  endfunction

  // Drive one operation; optionally inject a second strobe when k == inj_k,
  // where k counts rising edges after the capture edge (capture edge is k=0).
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic [7:0] og,
                        input int inj_k, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ig);
    logic [15:0] exp_v;
    int  k;
    int  busy_n;
    bit  fast;
    bit  seen;
    fast = (oa == 0) || (ob == 0) || (og == 0);
    exp_q.push_back(lcm_ref(oa, ob, og));
    @(negedge clk);
    a = oa; b = ob; gcd = og; in_valid = 1'b1;
    busy_n = 0;
    seen   = 1'b0;
    for (k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 0 && !fast) check_val("lcm_hold", lcm, exp_hold);
      if (busy) busy_n++;
      if (k == inj_k) begin
        a = ia; b = ib; gcd = ig; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    exp_v = exp_q.pop_front();
    if (!seen) begin
      check_val("done_timeout", 0, 1);
    end else begin
      check_val("latency", k, fast ? 0 : 16);
      check_val("busy_cycles", busy_n, fast ? 1 : 17);
      check_val("lcm", lcm, exp_v);
    end
    exp_hold = exp_v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("done_pulse", done, 0);
    check_val("idle_after", busy, 0);
    check_val("lcm_kept", lcm, exp_hold);
  endtask

  initial begin
    int done_seen;
    int ra, rb;
    n_checks = 0;
    n_fail   = 0;
    exp_hold = 16'd0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a = '0; b = '0; gcd = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_lcm", lcm, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd144, 8'd12, 8'd12, -1, 0, 0, 0);
    run_op(8'd12, 8'd18, 8'd6, -1, 0, 0, 0);
    run_op(8'd255, 8'd254, 8'd1, -1, 0, 0, 0);
    run_op(8'd0, 8'd5, 8'd5, -1, 0, 0, 0);
    run_op(8'd0, 8'd0, 8'd0, -1, 0, 0, 0);
    // strobe during MUL must be dropped
    run_op(8'd10, 8'd4, 8'd2, 10, 8'd9, 8'd6, 8'd3);
    run_op(8'd9, 8'd6, 8'd3, -1, 0, 0, 0);
    // strobe during DONE must be dropped
    run_op(8'd7, 8'd3, 8'd1, 16, 8'd5, 8'd5, 8'd5);

    // reset in the middle of DIV
    @(negedge clk);
    a = 8'd100; b = 8'd50; gcd = 8'd50; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("mid_state_div", state_dbg, DIV);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_lcm", lcm, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_hold  = 16'd0;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check_val("no_done_after_rst", done_seen, 0);
    run_op(8'd7, 8'd3, 8'd1, -1, 0, 0, 0);

    // operands as the upstream GCD block would deliver them
    run_op(8'd144, 8'd12, 8'(gcd_ref(144, 12)), -1, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      run_op(8'(ra), 8'(rb), 8'(gcd_ref(ra, rb)), -1, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
